// File: rtl/io_hub.sv
// io_hub: memory-mapped I/O window with debounced input channels,
// register-backed output channels and a sticky change-flag interrupt.
module io_hub #(
  parameter int unsigned IN_CH   = 2,
  parameter int unsigned OUT_CH  = 2,
  parameter int unsigned CH_W    = 16,
  parameter int unsigned DEB_CYC = 4,
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic                     io_read,
  input  logic                     io_write,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  input  logic [IN_CH*CH_W-1:0]    sw_in,
  output logic [OUT_CH*CH_W-1:0]   led_out,
  output logic                     irq
);

  localparam int unsigned    CW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYC - 1);
  localparam logic [4:0]     W_MASK   = 5'd30;
  localparam logic [4:0]     W_FLAG   = 5'd31;

  logic             hit;
  logic             rd_en;
  logic             wr_en;
  logic [4:0]       word;
  logic [31:0]      rd_val;

  logic [CH_W-1:0]  out_q  [OUT_CH];
  logic [CH_W-1:0]  s1     [IN_CH];
  logic [CH_W-1:0]  s2     [IN_CH];
  logic [CH_W-1:0]  stable [IN_CH];
  logic [CW-1:0]    cnt    [IN_CH];

  logic [IN_CH-1:0] irq_mask;
  logic [IN_CH-1:0] chg_flag;
  logic [IN_CH-1:0] deb_done;
  logic [IN_CH-1:0] clr;

  // Byte-lane bits and upper write-data bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  assign hit   = (addr[31:7] == IO_BASE[31:7]);
  assign word  = addr[6:2];
  assign rd_en = io_read & hit;
  assign wr_en = io_write & hit;
  assign irq   = |(chg_flag & irq_mask);

  // Debounce completion: input disagrees with stable value for the final count.
  always_comb begin
    deb_done = '0;
    for (int unsigned k = 0; k < IN_CH; k++) begin
      deb_done[k] = (s2[k] != stable[k]) && (cnt[k] == CNT_LAST);
    end
  end

  // Write-1-to-clear mask for the change flags.
  always_comb begin
    clr = '0;
    if (wr_en && word == W_FLAG) clr = wdata[IN_CH-1:0];
  end

  // Per-channel two-flop synchroniser and debounce counter.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < IN_CH; k++) begin
      if (reset) begin
        s1[k]     <= '0;
        s2[k]     <= '0;
        stable[k] <= '0;
        cnt[k]    <= '0;
      end else begin
        s1[k] <= sw_in[k*CH_W +: CH_W];
        s2[k] <= s1[k];
        if (s2[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (deb_done[k]) begin
          stable[k] <= s2[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Output registers, interrupt mask and sticky change flags (set beats clear).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < OUT_CH; k++) out_q[k] <= '0;
      irq_mask <= '0;
      chg_flag <= '0;
    end else begin
      for (int unsigned k = 0; k < OUT_CH; k++) begin
        if (wr_en && 32'(word) == k) out_q[k] <= wdata[CH_W-1:0];
      end
      if (wr_en && word == W_MASK) irq_mask <= wdata[IN_CH-1:0];
      chg_flag <= (chg_flag & ~clr) | deb_done;
    end
  end

  // Read mux over pre-write register values, zero-extended to 32 bits.
  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < OUT_CH; k++) begin
      if (32'(word) == k) rd_val[CH_W-1:0] = out_q[k];
    end
    for (int unsigned k = 0; k < IN_CH; k++) begin
      if (32'(word) == k + 16) rd_val[CH_W-1:0] = stable[k];
    end
    if (word == W_MASK) rd_val[IN_CH-1:0] = irq_mask;
    if (word == W_FLAG) rd_val[IN_CH-1:0] = chg_flag;
  end

  // Registered read data, held on cycles without a hit read.
  always_ff @(posedge clock) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= rd_val;
  end

  // Pack output channel registers onto the led bus.
  always_comb begin
    led_out = '0;
    for (int unsigned k = 0; k < OUT_CH; k++) begin
      led_out[k*CH_W +: CH_W] = out_q[k];
    end
  end

endmodule

// File: tb/tb_io_hub.sv
// Scoreboard bench for io_hub with default parameters.
module tb_io_hub;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        io_read;
  logic        io_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] sw_in;
  logic [31:0] led_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] B = 32'hFFFFFC00;

  io_hub #(
    .IN_CH(2), .OUT_CH(2), .CH_W(16), .DEB_CYC(4), .IO_BASE(32'hFFFFFC00)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .io_read(io_read),
    .io_write(io_write), .wdata(wdata), .rdata(rdata), .sw_in(sw_in),
    .led_out(led_out), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: a hit read sampled at an edge must produce the next queued value.
  always begin
    logic v;
    @(posedge clock);
    v = io_read && !reset && ((addr & 32'hFFFFFF80) == B);
    #1;
    if (v) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    addr = a; io_read = 1'b1;
    exp_q.push_back(e);
    cyc();
    io_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; io_write = 1'b1;
    cyc();
    io_write = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    addr = a; wdata = d; io_write = 1'b1; io_read = 1'b1;
    exp_q.push_back(e);
    cyc();
    io_write = 1'b0; io_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; addr = '0; io_read = 1'b0; io_write = 1'b0; wdata = '0;
    sw_in = '1;
    cyc(2);
    chk("rst_led", led_out, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // Release with pins high: flags set 6 edges later.
    reset = 1'b0;
    wr(B + 32'h78, 32'h3);
    cyc(4);
    chk("rel_irq_e5", {31'h0, irq}, 32'h0);
    cyc();
    chk("rel_irq_e6", {31'h0, irq}, 32'h1);
    rd(B + 32'h7C, 32'h3);
    rd(B + 32'h40, 32'hFFFF);
    rd(B + 32'h44, 32'hFFFF);

    // Mask and clear.
    wr(B + 32'h78, 32'h0);
    chk("mask0_irq", {31'h0, irq}, 32'h0);
    wr(B + 32'h78, 32'h2);
    chk("mask2_irq", {31'h0, irq}, 32'h1);
    wr(B + 32'h7C, 32'h2);
    chk("clr2_irq", {31'h0, irq}, 32'h0);
    rd(B + 32'h7C, 32'h1);
    rd(B + 32'h78, 32'h2);
    wr(B + 32'h7C, 32'h3);
    rd(B + 32'h7C, 32'h0);

    // Output write and readback.
    wr(B + 32'h04, 32'h0000BEEF);
    chk("led_beef", led_out, 32'hBEEF0000);
    rd(B + 32'h04, 32'h0000BEEF);
    rd(B + 32'h00, 32'h0);
    wr(B + 32'h00, 32'h12345678);
    chk("led_5678", led_out, 32'hBEEF5678);

    // Input channels: ch0 -> 0, ch1 -> 0x1234.
    sw_in = 32'h12340000;
    cyc(6);
    rd(B + 32'h44, 32'h00001234);
    rd(B + 32'h40, 32'h0);
    rd(B + 32'h7C, 32'h3);
    wr(B + 32'h7C, 32'h3);
    wr(B + 32'h78, 32'h3);

    // 3-cycle glitch on bit 0 is rejected.
    sw_in[0] = 1'b1;
    cyc(3);
    sw_in[0] = 1'b0;
    cyc(6);
    chk("glitch_irq", {31'h0, irq}, 32'h0);
    rd(B + 32'h40, 32'h0);
    rd(B + 32'h7C, 32'h0);

    // Held high: accepted on the 6th edge.
    sw_in[0] = 1'b1;
    cyc(5);
    chk("hold_irq_e5", {31'h0, irq}, 32'h0);
    cyc();
    chk("hold_irq_e6", {31'h0, irq}, 32'h1);
    rd(B + 32'h40, 32'h1);
    rd(B + 32'h7C, 32'h1);

    // Clear on the same edge as a new completion: set wins.
    sw_in[0] = 1'b0;
    wr(B + 32'h7C, 32'h1);
    cyc(4);
    chk("setwin_pre", {31'h0, irq}, 32'h0);
    wr(B + 32'h7C, 32'h1);
    chk("setwin_irq", {31'h0, irq}, 32'h1);
    rd(B + 32'h7C, 32'h1);
    rd(B + 32'h40, 32'h0);

    // Read and write of the same register in one cycle returns the old value.
    rdwr(B + 32'h04, 32'h0000CAFE, 32'h0000BEEF);
    chk("rdwr_led", led_out, 32'hCAFE5678);
    rd(B + 32'h04, 32'h0000CAFE);

    // Unmapped, IN and off-window accesses.
    rd(B + 32'h60, 32'h0);
    wr(B + 32'h50, 32'hFFFFFFFF);
    rd(B + 32'h50, 32'h0);
    wr(B + 32'h40, 32'hFFFF);
    rd(B + 32'h40, 32'h0);
    wr(32'hFFFFF804, 32'h0000AAAA);
    chk("offwin_led", led_out, 32'hCAFE5678);
    rd(B + 32'h06, 32'h0000CAFE);
    cyc(2);
    chk("rdata_hold", rdata, 32'h0000CAFE);
    addr = 32'hFFFFF800; io_read = 1'b1;
    cyc();
    io_read = 1'b0;
    chk("rdata_offwin", rdata, 32'h0000CAFE);

    // Mid-debounce reset with outputs set.
    wr(B + 32'h00, 32'h0000FFFF);
    chk("led_ffff", led_out, 32'hCAFEFFFF);
    sw_in = 32'h12340001;
    cyc(4);
    reset = 1'b1;
    cyc();
    chk("mid_rst_led", led_out, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    wr(B + 32'h78, 32'h1);
    cyc(4);
    chk("rerun_irq_e5", {31'h0, irq}, 32'h0);
    cyc();
    chk("rerun_irq_e6", {31'h0, irq}, 32'h1);
    rd(B + 32'h7C, 32'h3);
    rd(B + 32'h40, 32'h1);
    rd(B + 32'h44, 32'h00001234);
    rd(B + 32'h00, 32'h0);

    cyc(2);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
